// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: steers the external PC counter, issues imem req/ack fetches, buffers one instruction for decode.
// Latency: first request two cycles after reset release, instr_valid the cycle after imem_ack, one instruction per two cycles.
// Backpressure: a held instruction stalls fetch until instr_ready; a missing imem_ack holds the request and pulses fetch_fault.
module fetch_sequencer #(
    parameter logic [15:0] TRAP_VECTOR    = 16'h0100,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic        pc_ctrl,
    output logic [15:0] pc_next,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        trap_valid,
    output logic        fetch_fault
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          redir;
    logic [15:0]   target;
    logic [15:0]   fetch_pc;
    logic          advance;

    // Trap entry outranks a branch/jump redirect in the same cycle.
    always_comb begin
        redir    = trap_valid | redirect_valid;
        target   = trap_valid ? TRAP_VECTOR : redirect_target;
        fetch_pc = redir ? target : pc;
        advance  = (state == REQ) && imem_ack && !redir;
        pc_ctrl  = 1'b1;
        pc_next  = pc;
        if (rst) begin
            pc_next = 16'h0000;
        end else if (redir) begin
            pc_next = target;
        end else if (advance) begin
            pc_ctrl = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            imem_req    <= 1'b0;
            imem_addr   <= 16'h0000;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 16'h0000;
            fetch_fault <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            fetch_fault <= 1'b0;
            case (state)
                BOOT: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redir) begin
                            imem_addr <= target;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (redir) begin
                        state <= DRAIN;
                    end
                end
                // Old fetch must complete before the bus can be reused; its data is dropped.
                DRAIN: begin
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= fetch_pc;
                    end
                end
                HOLD: begin
                    if (redir || (instr_valid && instr_ready)) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= fetch_pc;
                        state       <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase

            // Request is never withdrawn on timeout; fault is purely a report.
            if (!imem_req || imem_ack) begin
                wait_cnt <= '0;
            end else if (wait_cnt == CNT_LAST) begin
                wait_cnt    <= '0;
                fetch_fault <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the 16-bit program counter register and the instruction-memory port. It drives the counter's load/increment control, issues req/ack fetches to instruction memory and buffers one instruction for decode under a valid/ready handshake. It also applies branch/jump redirects and trap entry. It sits between the program counter, the instruction memory and the decode stage.

## Interface
- TRAP_VECTOR, 16'h0100, PC loaded on trap entry
- TIMEOUT_CYCLES, 64, consecutive unacknowledged request cycles before fetch_fault pulses (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  16  current program counter value
- pc_ctrl  out  1  to counter: 1 = load pc_next, 0 = increment by 4
- pc_next  out  16  load value for counter
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  16  fetch address (registered)
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  buffered instruction available
- instr  out  32  buffered instruction
- instr_pc  out  16  address of instr
- instr_ready  in  1  decode accepts instr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  16  redirect destination
- trap_valid  in  1  trap entry this cycle
- fetch_fault  out  1  one-cycle pulse on fetch timeout

## Operation
- States: BOOT, REQ, HOLD, DRAIN.
- pc_ctrl and pc_next are combinational. Default is pc_ctrl=1, pc_next=pc, so the PC is held.
- Redirect source priority: trap_valid > redirect_valid. Effective target is TRAP_VECTOR or redirect_target. On redirect, pc_ctrl=1 and pc_next=target.
- Entering REQ always loads imem_addr with the value pc will hold after the edge.
- BOOT: no request. Next state is REQ with imem_addr=pc, or target on redirect.
- REQ: imem_req=1.
  - On imem_ack without redirect: capture instr=imem_rdata, instr_pc=imem_addr, set instr_valid=1, drive pc_ctrl=0 (PC+4), go HOLD.
  - On imem_ack with redirect: discard data, go REQ at target.
  - On redirect without ack: go DRAIN.
- DRAIN: imem_req=1, imem_addr unchanged (old fetch completes). Redirect here updates PC only.
  - On ack: discard data, go REQ at pc, or at target if a redirect is also present.
- HOLD: imem_req=0, PC held.
  - Transfer when instr_valid & instr_ready: clear instr_valid, go REQ at pc.
  - On redirect: clear instr_valid, go REQ at target. A transfer in the same cycle still counts as delivered.
- Timeout: counter increments each cycle imem_req=1 & !imem_ack and clears on ack, on rst, or when leaving REQ/DRAIN.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, fetch_fault pulses next cycle and the counter clears.
  - The request stays asserted (retry by waiting).
- PC changes only when pc_ctrl=0 (ack in REQ) or on redirect.

## Timing
- Reset values:
  - State is BOOT.
  - imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, counter=0.
  - While rst=1, force pc_ctrl=1 and pc_next=16'h0000.
- Reset mid-fetch abandons the request immediately. imem_req is 0 in the cycle after rst is sampled.
- First request is asserted 2 cycles after rst deasserts (BOOT, then REQ).
- Throughput with single-cycle ack and ready held high: one instruction per 2 cycles (REQ, HOLD).
- instr_valid rises the cycle after ack. Redirect takes effect on PC at the next edge.
- The first request at a redirect target appears the next cycle, or 1 cycle after the outstanding ack when draining.
- imem_addr and imem_req are stable while imem_req=1 and ack is low.

## Test plan
- Sequential fetch:
  - Stimulus: reset, imem_ack one cycle after every req, instr_ready=1.
  - Required: imem_addr sequence 0x0000, 0x0004, 0x0008; instr_pc matches; one instruction every 2 cycles.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles in HOLD.
  - Required: instr_valid stays 1, instr stable, pc constant, imem_req=0. Refetch starts the cycle after ready rises.
- Redirect during outstanding fetch:
  - Stimulus: req to 0x0010 pending; redirect_valid with target 0x0200; ack arrives 3 cycles later.
  - Required: PC becomes 0x0200 next edge, data from 0x0010 never appears on instr, next imem_addr=0x0200.
- Trap vs branch:
  - Stimulus: trap_valid and redirect_valid (0x0300) in the same HOLD cycle.
  - Required: next fetch at 0x0100, instr_valid cleared.
- Timeout:
  - Stimulus: withhold imem_ack for 130 cycles.
  - Required: fetch_fault pulses exactly twice (cycles 64, 128 of waiting), req held, normal capture on the eventual ack.
- Reset mid-HOLD:
  - Stimulus: assert rst with instr_valid=1.
  - Required: all outputs at reset values next cycle; fetch resumes at 0x0000.
